// File: rtl/video_timing_pkg.sv
// Mode timing table, mode encoding and lookup helpers shared by the
// multi-mode video timing generator.
package video_timing_pkg;

    localparam int TIM_W     = 12;
    localparam int NUM_MODES = 3;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_1280X720 = 2'd2
    } mode_e;

    typedef struct packed {
        logic [TIM_W-1:0] h_sync;
        logic [TIM_W-1:0] h_back;
        logic [TIM_W-1:0] h_disp;
        logic [TIM_W-1:0] h_front;
        logic [TIM_W-1:0] h_total;
        logic [TIM_W-1:0] v_sync;
        logic [TIM_W-1:0] v_back;
        logic [TIM_W-1:0] v_disp;
        logic [TIM_W-1:0] v_front;
        logic [TIM_W-1:0] v_total;
        logic             h_pol;
        logic             v_pol;
    } timing_t;

    // Polarity bit is the active level of the sync pulse (1 = positive).
    localparam timing_t MODE_TABLE [NUM_MODES] = '{
        '{12'd96,  12'd48,  12'd640,  12'd16,  12'd800,
          12'd2,   12'd33,  12'd480,  12'd10,  12'd525, 1'b0, 1'b0},
        '{12'd128, 12'd88,  12'd800,  12'd40,  12'd1056,
          12'd4,   12'd23,  12'd600,  12'd1,   12'd628, 1'b1, 1'b1},
        '{12'd40,  12'd220, 12'd1280, 12'd110, 12'd1650,
          12'd5,   12'd20,  12'd720,  12'd5,   12'd750, 1'b1, 1'b1}
    };

    function automatic mode_e map_mode(input logic [1:0] sel);
        mode_e m;
        case (sel)
            2'd1:    m = MODE_800X600;
            2'd2:    m = MODE_1280X720;
            default: m = MODE_640X480;
        endcase
        return m;
    endfunction

    function automatic timing_t mode_timing(input mode_e m);
        timing_t t;
        case (m)
            MODE_800X600:  t = MODE_TABLE[1];
            MODE_1280X720: t = MODE_TABLE[2];
            default:       t = MODE_TABLE[0];
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_hv_counter.sv
// Horizontal/vertical raster counters with wrap and an end-of-frame flag
// raised on the last pixel of the last line.
module video_hv_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] h_total_i,
    input  logic [CNT_W-1:0] v_total_i,
    output logic [CNT_W-1:0] cnt_h_o,
    output logic [CNT_W-1:0] cnt_v_o,
    output logic             frame_end_o
);

    logic [CNT_W-1:0] cnt_h_q;
    logic [CNT_W-1:0] cnt_h_d;
    logic [CNT_W-1:0] cnt_v_q;
    logic [CNT_W-1:0] cnt_v_d;
    logic             h_end_s;
    logic             v_end_s;

    // Next-state for both counters; >= keeps the wrap safe against any out-of-range value.
    always_comb begin
        h_end_s = (cnt_h_q >= (h_total_i - CNT_W'(1)));
        v_end_s = (cnt_v_q >= (v_total_i - CNT_W'(1)));
        cnt_h_d = cnt_h_q;
        cnt_v_d = cnt_v_q;
        if (h_end_s) begin
            cnt_h_d = '0;
            if (v_end_s) begin
                cnt_v_d = '0;
            end else begin
                cnt_v_d = cnt_v_q + CNT_W'(1);
            end
        end else begin
            cnt_h_d = cnt_h_q + CNT_W'(1);
            cnt_v_d = cnt_v_q;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    assign cnt_h_o     = cnt_h_q;
    assign cnt_v_o     = cnt_v_q;
    assign frame_end_o = h_end_s && v_end_s;

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator: HS/VS/DE, pixel request with coordinates
// issued REQ_LEAD cycles ahead, registered RGB, and frame-boundary mode switching.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int CNT_W    = 12,
    parameter int REQ_LEAD = 1
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,
    input  logic [1:0]        mode_sel,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              data_req,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [DATA_W-1:0] video_rgb,
    output logic              frame_start,
    output logic              line_start,
    output logic [1:0]        cur_mode
);

    mode_e            sel_mode_s;
    mode_e            cur_mode_q;
    mode_e            cur_mode_d;
    timing_t          tm_s;
    timing_t          tm_sel_s;

    logic [CNT_W-1:0] cnt_h_s;
    logic [CNT_W-1:0] cnt_v_s;
    logic             frame_end_s;

    logic [CNT_W-1:0] h_total_s;
    logic [CNT_W-1:0] v_total_s;
    logic [CNT_W-1:0] h_sync_s;
    logic [CNT_W-1:0] v_sync_s;
    logic [CNT_W-1:0] h_act_start_s;
    logic [CNT_W-1:0] h_act_end_s;
    logic [CNT_W-1:0] v_act_start_s;
    logic [CNT_W-1:0] v_act_end_s;
    logic [CNT_W-1:0] req_start_s;
    logic [CNT_W-1:0] req_end_s;

    logic             v_act_s;
    logic             req_s;
    logic [CNT_W-1:0] xpos_s;
    logic [CNT_W-1:0] ypos_s;

    logic              hs_d;
    logic              vs_d;
    logic              de_d;
    logic [DATA_W-1:0] rgb_d;
    logic              fs_d;
    logic              ls_d;
    logic              hs_q;
    logic              vs_q;
    logic              de_q;
    logic [DATA_W-1:0] rgb_q;
    logic              fs_q;
    logic              ls_q;

    // Timing set of the active mode and of the mode requested on mode_sel.
    always_comb begin
        sel_mode_s    = map_mode(mode_sel);
        tm_s          = mode_timing(cur_mode_q);
        tm_sel_s      = mode_timing(sel_mode_s);
        h_total_s     = CNT_W'(tm_s.h_total);
        v_total_s     = CNT_W'(tm_s.v_total);
        h_sync_s      = CNT_W'(tm_s.h_sync);
        v_sync_s      = CNT_W'(tm_s.v_sync);
        h_act_start_s = CNT_W'(tm_s.h_sync) + CNT_W'(tm_s.h_back);
        h_act_end_s   = h_act_start_s + CNT_W'(tm_s.h_disp);
        v_act_start_s = CNT_W'(tm_s.v_sync) + CNT_W'(tm_s.v_back);
        v_act_end_s   = v_act_start_s + CNT_W'(tm_s.v_disp);
        req_start_s   = h_act_start_s - CNT_W'(REQ_LEAD);
        req_end_s     = h_act_end_s - CNT_W'(REQ_LEAD);
    end

    video_hv_counter #(
        .CNT_W (CNT_W)
    ) u_hv (
        .clk_i       (pixel_clk),
        .rst_i       (sys_rst),
        .h_total_i   (h_total_s),
        .v_total_i   (v_total_s),
        .cnt_h_o     (cnt_h_s),
        .cnt_v_o     (cnt_v_s),
        .frame_end_o (frame_end_s)
    );

    // A new mode is adopted only on the last pixel of a frame, so it starts cleanly at (0,0).
    always_comb begin
        cur_mode_d = cur_mode_q;
        if (frame_end_s) begin
            cur_mode_d = sel_mode_s;
        end else begin
            cur_mode_d = cur_mode_q;
        end
    end

    // Mode register; reset loads the requested mode directly.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            cur_mode_q <= sel_mode_s;
        end else begin
            cur_mode_q <= cur_mode_d;
        end
    end

    // Pixel request window, shifted REQ_LEAD columns ahead of the display window.
    always_comb begin
        v_act_s    = (cnt_v_s >= v_act_start_s) && (cnt_v_s < v_act_end_s);
        req_s      = 1'b0;
        xpos_s     = '0;
        ypos_s     = '0;
        if (!sys_rst && v_act_s && (cnt_h_s >= req_start_s) && (cnt_h_s < req_end_s)) begin
            req_s  = 1'b1;
            xpos_s = cnt_h_s - req_start_s;
            ypos_s = cnt_v_s - v_act_start_s;
        end else begin
            req_s  = 1'b0;
            xpos_s = '0;
            ypos_s = '0;
        end
    end

    // Next values of the registered video outputs from the current counter state.
    always_comb begin
        hs_d  = (cnt_h_s < h_sync_s) ? tm_s.h_pol : ~tm_s.h_pol;
        vs_d  = (cnt_v_s < v_sync_s) ? tm_s.v_pol : ~tm_s.v_pol;
        de_d  = v_act_s && (cnt_h_s >= h_act_start_s) && (cnt_h_s < h_act_end_s);
        rgb_d = '0;
        if (de_d) begin
            rgb_d = pixel_data;
        end else begin
            rgb_d = '0;
        end
        fs_d  = (cnt_h_s == '0) && (cnt_v_s == '0);
        ls_d  = (cnt_h_s == '0);
    end

    // Output registers; syncs idle at the inactive level of the mode being latched.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            hs_q  <= ~tm_sel_s.h_pol;
            vs_q  <= ~tm_sel_s.v_pol;
            de_q  <= 1'b0;
            rgb_q <= '0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
        end
    end

    assign data_req    = req_s;
    assign pixel_xpos  = xpos_s;
    assign pixel_ypos  = ypos_s;
    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign video_rgb   = rgb_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign cur_mode    = cur_mode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a raster-position reference model
// checked every cycle, a reset vector table and hand-written corner sequences.
module tb_video_timing_gen;

    localparam int DW   = 24;
    localparam int CW   = 12;
    localparam int LEAD = 2;

    localparam int R_HS [3] = '{96, 128, 40};
    localparam int R_HB [3] = '{48, 88, 220};
    localparam int R_HD [3] = '{640, 800, 1280};
    localparam int R_HT [3] = '{800, 1056, 1650};
    localparam int R_VS [3] = '{2, 4, 5};
    localparam int R_VB [3] = '{33, 23, 20};
    localparam int R_VD [3] = '{480, 600, 720};
    localparam int R_VT [3] = '{525, 628, 750};
    localparam int R_HP [3] = '{0, 1, 1};
    localparam int R_VP [3] = '{0, 1, 1};

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [1:0]    mode_sel;
    logic [DW-1:0] pixel_data;
    logic          data_req;
    logic [CW-1:0] pixel_xpos;
    logic [CW-1:0] pixel_ypos;
    logic          video_hs;
    logic          video_vs;
    logic          video_de;
    logic [DW-1:0] video_rgb;
    logic          frame_start;
    logic          line_start;
    logic [1:0]    cur_mode;

    always #5 clk = ~clk;

    video_timing_gen #(
        .DATA_W   (DW),
        .CNT_W    (CW),
        .REQ_LEAD (LEAD)
    ) dut (
        .pixel_clk   (clk),
        .sys_rst     (sys_rst),
        .mode_sel    (mode_sel),
        .pixel_data  (pixel_data),
        .data_req    (data_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .video_rgb   (video_rgb),
        .frame_start (frame_start),
        .line_start  (line_start),
        .cur_mode    (cur_mode)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] exp_mode;
        logic       exp_hs;
        logic       exp_vs;
    } rst_vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            npos;
    int            nmode;
    int            de_cnt;
    int            de_ok;
    int            last_hd;
    logic [DW-1:0] hist [0:8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mapm(input int s);
        return (s == 3) ? 0 : s;
    endfunction

    // One clock: compare DUT against the raster-position model, then act as the pixel source.
    task automatic step();
        logic r;
        int   ms, p, m, h, v, ah, av;
        bit   de_e, req_e;
        r  = sys_rst;
        ms = int'(mode_sel);
        @(posedge clk);
        #1;
        if (r) begin
            m = mapm(ms);
            chk("rst_de", longint'(video_de), 0);
            chk("rst_rgb", longint'(video_rgb), 0);
            chk("rst_fs", longint'(frame_start), 0);
            chk("rst_ls", longint'(line_start), 0);
            chk("rst_hs", longint'(video_hs), longint'(R_HP[m] == 0));
            chk("rst_vs", longint'(video_vs), longint'(R_VP[m] == 0));
            npos   = 0;
            nmode  = m;
            de_cnt = 0;
            de_ok  = 0;
        end else begin
            p  = npos;
            m  = nmode;
            h  = p % R_HT[m];
            v  = p / R_HT[m];
            ah = R_HS[m] + R_HB[m];
            av = R_VS[m] + R_VB[m];
            de_e = (h >= ah) && (h < ah + R_HD[m]) && (v >= av) && (v < av + R_VD[m]);
            chk("hs", longint'(video_hs), longint'((h < R_HS[m]) ? R_HP[m] : 1 - R_HP[m]));
            chk("vs", longint'(video_vs), longint'((v < R_VS[m]) ? R_VP[m] : 1 - R_VP[m]));
            chk("de", longint'(video_de), longint'(de_e));
            chk("rgb", longint'(video_rgb), de_e ? longint'(((v - av) << 12) | (h - ah)) : 0);
            chk("frame_start", longint'(frame_start), longint'(p == 0));
            chk("line_start", longint'(line_start), longint'(h == 0));
            if (h == 0) begin
                if (de_ok != 0 && de_cnt > 0) chk("de_per_line", longint'(de_cnt), longint'(last_hd));
                de_cnt = 0;
                de_ok  = 1;
            end
            if (video_de) begin
                de_cnt++;
                last_hd = R_HD[m];
            end
            npos = p + 1;
            if (npos == R_HT[m] * R_VT[m]) begin
                npos  = 0;
                nmode = mapm(ms);
            end
        end
        chk("cur_mode", longint'(cur_mode), longint'(nmode));
        m  = nmode;
        h  = npos % R_HT[m];
        v  = npos / R_HT[m];
        ah = R_HS[m] + R_HB[m];
        av = R_VS[m] + R_VB[m];
        req_e = !sys_rst && (h >= ah - LEAD) && (h < ah + R_HD[m] - LEAD) &&
                (v >= av) && (v < av + R_VD[m]);
        chk("data_req", longint'(data_req), longint'(req_e));
        chk("xpos", longint'(pixel_xpos), req_e ? longint'(h - (ah - LEAD)) : 0);
        chk("ypos", longint'(pixel_ypos), req_e ? longint'(v - av) : 0);
        for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
        hist[0]    = data_req ? {pixel_ypos, pixel_xpos} : DW'($urandom);
        pixel_data = hist[LEAD];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Jump the vertical counter to line tv at column 5 to reach far corners of a frame quickly.
    task automatic skip_to_line(input int tv);
        int guard;
        guard = 0;
        while ((npos % R_HT[nmode]) != 5 && guard < 2000) begin
            step();
            guard++;
        end
        force dut.u_hv.cnt_v_q = CW'(tv);
        npos = tv * R_HT[nmode] + 5;
        step();
        release dut.u_hv.cnt_v_q;
    endtask

    initial begin
        rst_vec_t rv [4];
        int       k;
        int       hl;
        int       vl;

        rv[0] = '{2'd0, 2'd0, 1'b1, 1'b1};
        rv[1] = '{2'd2, 2'd2, 1'b0, 1'b0};
        rv[2] = '{2'd3, 2'd0, 1'b1, 1'b1};
        rv[3] = '{2'd1, 2'd1, 1'b0, 1'b0};

        sys_rst    = 1'b1;
        mode_sel   = 2'd1;
        pixel_data = '0;
        npos       = 0;
        nmode      = 1;
        de_cnt     = 0;
        de_ok      = 0;
        last_hd    = 0;
        for (int i = 0; i < 9; i++) hist[i] = '0;

        // Reset vector table: mode latch and idle sync levels per mode_sel.
        for (int i = 0; i < 4; i++) begin
            mode_sel = rv[i].sel;
            step();
            chk("tbl_cur_mode", longint'(cur_mode), longint'(rv[i].exp_mode));
            chk("tbl_hs", longint'(video_hs), longint'(rv[i].exp_hs));
            chk("tbl_vs", longint'(video_vs), longint'(rv[i].exp_vs));
            chk("tbl_req", longint'(data_req), 0);
        end

        // 800x600: release, first line, first active pixel.
        sys_rst = 1'b0;
        hl = 0;
        for (int i = 0; i < 1056; i++) begin
            step();
            if (i == 0) chk("fs_after_release", longint'(frame_start), 1);
            if (video_hs) hl++;
        end
        chk("m1_hs_high_cycles", longint'(hl), 128);
        run(50);
        skip_to_line(26);
        k = 0;
        while (!video_de && k < 3000) begin
            step();
            k++;
        end
        chk("m1_first_de_delay", longint'(k), 1267);
        run(4 * 1056);

        // Mode switch request mid-frame with glitches; adopted only at the frame boundary.
        run(300);
        skip_to_line(627);
        k = 0;
        while (cur_mode != 2'd2 && k < 1100) begin
            mode_sel = (k < 600) ? 2'($urandom_range(0, 3)) : 2'd2;
            step();
            k++;
        end
        chk("mode_switch_cycles", longint'(k), 1050);
        step();
        chk("fs_new_mode", longint'(frame_start), 1);
        run(2 * 1650);
        skip_to_line(23);
        run(4 * 1650);
        skip_to_line(749);
        run(1700);

        // mode_sel = 3 during reset selects 640x480.
        mode_sel = 2'd3;
        sys_rst  = 1'b1;
        run(3);
        sys_rst = 1'b0;
        hl = 0;
        vl = 0;
        for (int i = 0; i < 2400; i++) begin
            step();
            if (i < 800 && !video_hs) hl++;
            if (!video_vs) vl++;
        end
        chk("m0_hs_low_cycles", longint'(hl), 96);
        chk("m0_vs_low_cycles", longint'(vl), 1600);
        skip_to_line(34);
        run(2 * 800);

        // Reset asserted mid-line at line 300 for three cycles.
        skip_to_line(300);
        run(200);
        sys_rst = 1'b1;
        step();
        chk("midrst_de", longint'(video_de), 0);
        chk("midrst_hs", longint'(video_hs), 1);
        chk("midrst_req", longint'(data_req), 0);
        run(2);
        sys_rst = 1'b0;
        step();
        chk("midrst_fs", longint'(frame_start), 1);
        run(2 * 800);
        skip_to_line(524);
        run(900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
